instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_req  output  1  instruction memory read request.
REQ-005 SHALL have port mem_addr  output  32  word address of the request, equal to the current PC.
REQ-006 SHALL have port mem_ready  input  1  memory returns mem_rdata valid this cycle.
REQ-007 SHALL have port mem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port pc_redirect  input  1  branch/jump taken; load pc_target.
REQ-009 SHALL have port pc_target  input  32  redirect destination.
REQ-010 SHALL have port stall  input  1  downstream not ready to consume the held instruction.
REQ-011 SHALL have port full_instruction  output  32  registered instruction word for the decode/immediate stage.
REQ-012 SHALL have port instruction_pc  output  32  PC of full_instruction.
REQ-013 SHALL have port instruction_valid  output  1  full_instruction is valid and not yet consumed.
REQ-014 SHALL have port immediate_source  output  3  registered immediate format select for full_instruction.
REQ-015 SHALL have port illegal_opcode  output  1  registered; opcode of full_instruction is not RV32I.

Function
REQ-016 SHALL implement a two-state FSM: FETCH, HOLD.
REQ-017 FETCH: mem_req=1, mem_addr=pc; on mem_ready=1: full_instruction<=mem_rdata, instruction_pc<=pc, instruction_valid<=1, pc<=pc+4, next state HOLD; else remain in FETCH with mem_req=1 and pc unchanged.
REQ-018 HOLD: mem_req=0, instruction_valid=1, outputs stable; stall=1 keeps HOLD; stall=0 consumes: next cycle instruction_valid=0, state FETCH.
REQ-019 Fetch latency: instruction_valid rises the cycle after the edge on which mem_ready=1 is sampled; minimum 2 cycles per instruction.
REQ-020 pc_redirect=1 in any state (priority over mem_ready and stall): pc<={pc_target[31:2],2'b00}, instruction_valid<=0, state FETCH; mem_rdata returned in that same cycle SHALL be discarded.
REQ-021 PC increment SHALL be modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-022 mem_ready while in HOLD SHALL be ignored.
REQ-023 immediate_source SHALL be decoded from mem_rdata[6:0] and registered with full_instruction: 0010011/0000011/1100111 -> 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 1101111 -> 011 (J); 0110111/0010111 -> 100 (U); all others -> 000.
REQ-024 illegal_opcode SHALL be 1 iff latched opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011.
REQ-025 mem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-026 reset=1 at a rising edge SHALL set pc=RESET_PC, state=FETCH, full_instruction=0, instruction_pc=0, instruction_valid=0, immediate_source=000, illegal_opcode=0.
REQ-027 reset SHALL take priority over pc_redirect, mem_ready and stall, including mid-fetch and in HOLD.
REQ-028 mem_req SHALL be 1 on the first cycle after reset deasserts, with mem_addr=RESET_PC.

Verification
REQ-029 Reset, mem_ready=1 constant, mem_rdata=32'h00500093, stall=0 -> mem_addr 0x0,0x4,0x8; instruction_valid pulses every 2nd cycle; immediate_source=000, illegal_opcode=0.
REQ-030 mem_ready held 0 for 3 cycles after reset -> mem_req=1, mem_addr=0x0 constant, instruction_valid=0; on ready with 32'h00112023 -> valid=1, immediate_source=001, instruction_pc=0x0.
REQ-031 HOLD with stall=1 for 4 cycles -> full_instruction, instruction_pc, instruction_valid=1 unchanged, mem_req=0; stall=0 -> valid=0 next cycle, mem_addr=0x4.
REQ-032 pc_redirect=1, pc_target=32'h00000103, same cycle as mem_ready=1 -> data discarded, instruction_valid=0, next mem_addr=0x100.
REQ-033 Redirect to 0xFFFFFFFC, fetch 32'h0000006F -> immediate_source=011; next mem_addr=0x00000000.
REQ-034 mem_rdata=32'h0000007F fetched -> illegal_opcode=1, immediate_source=000; reset asserted in HOLD -> all outputs at REQ-026 values next cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, memory request and registered instruction/immediate-format/illegal-opcode decode.
// Latency: valid rises the cycle after mem_ready is sampled (2 cycles minimum); stall holds the word, pc_redirect flushes it.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  input  logic        stall,
  output logic [31:0] full_instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  output logic [2:0]  immediate_source,
  output logic        illegal_opcode
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [2:0]  imm_dec;
  logic        ill_dec;

  assign mem_req  = (state == FETCH);
  assign mem_addr = {pc[31:2], 2'b00};

  always_comb begin
    imm_dec = 3'b000;
    ill_dec = 1'b0;
    case (mem_rdata[6:0])
      7'b0110011: imm_dec = 3'b000;
      7'b0010011: imm_dec = 3'b000;
      7'b0000011: imm_dec = 3'b000;
      7'b1100111: imm_dec = 3'b000;
      7'b0100011: imm_dec = 3'b001;
      7'b1100011: imm_dec = 3'b010;
      7'b1101111: imm_dec = 3'b011;
      7'b0110111: imm_dec = 3'b100;
      7'b0010111: imm_dec = 3'b100;
      7'b0001111: imm_dec = 3'b000;
      7'b1110011: imm_dec = 3'b000;
      default:    ill_dec = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      full_instruction  <= 32'h0;
      instruction_pc    <= 32'h0;
      instruction_valid <= 1'b0;
      immediate_source  <= 3'b000;
      illegal_opcode    <= 1'b0;
    end else if (pc_redirect) begin
      // Any word returned alongside a redirect belongs to the wrong path.
      pc                <= {pc_target[31:2], 2'b00};
      instruction_valid <= 1'b0;
      state             <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            full_instruction  <= mem_rdata;
            instruction_pc    <= pc;
            instruction_valid <= 1'b1;
            immediate_source  <= imm_dec;
            illegal_opcode    <= ill_dec;
            pc                <= pc + 32'd4;
            state             <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instruction_valid <= 1'b0;
            state             <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        pc_redirect = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] full_instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic [2:0]  immediate_source;
  logic        illegal_opcode;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .stall(stall), .full_instruction(full_instruction),
    .instruction_pc(instruction_pc), .instruction_valid(instruction_valid),
    .immediate_source(immediate_source), .illegal_opcode(illegal_opcode)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_fi;
    logic [31:0] e_ipc;
    logic [2:0]  e_imm;
    logic        e_ill;
  } vec_t;

  vec_t vt[26];

  function automatic vec_t mk(logic rst, logic rdy, logic [31:0] rdata, logic redir,
                              logic [31:0] tgt, logic stl, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_fi, logic [31:0] e_ipc,
                              logic [2:0] e_imm, logic e_ill);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.redir = redir; v.tgt = tgt; v.stl = stl;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_fi = e_fi;
    v.e_ipc = e_ipc; v.e_imm = e_imm; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic rst, input logic rdy, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] tgt, input logic stl);
    @(negedge clk);
    reset = rst; mem_ready = rdy; mem_rdata = rdata;
    pc_redirect = redir; pc_target = tgt; stall = stl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] LUI  = 32'h00000037;
  localparam logic [31:0] BAD  = 32'h0000007F;

  initial begin
    bit got;
    //            rst rdy rdata redir tgt stl | req addr vld fi ipc imm ill
    vt[0]  = mk(1, 0, 0,    0, 0, 0,   1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);
    vt[1]  = mk(0, 1, ADDI, 0, 0, 0,   0, 32'h4, 1, ADDI, 32'h0, 3'd0, 0);
    vt[2]  = mk(0, 1, ADDI, 0, 0, 0,   1, 32'h4, 0, ADDI, 32'h0, 3'd0, 0);
    vt[3]  = mk(0, 1, ADDI, 0, 0, 0,   0, 32'h8, 1, ADDI, 32'h4, 3'd0, 0);
    vt[4]  = mk(0, 1, ADDI, 0, 0, 0,   1, 32'h8, 0, ADDI, 32'h4, 3'd0, 0);
    vt[5]  = mk(0, 1, ADDI, 0, 0, 0,   0, 32'hC, 1, ADDI, 32'h8, 3'd0, 0);
    vt[6]  = mk(0, 1, ADDI, 0, 0, 0,   1, 32'hC, 0, ADDI, 32'h8, 3'd0, 0);
    vt[7]  = mk(1, 0, 0,    0, 0, 0,   1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);
    vt[8]  = mk(0, 0, SW,   0, 0, 0,   1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);
    vt[9]  = mk(0, 0, SW,   0, 0, 0,   1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);
    vt[10] = mk(0, 0, SW,   0, 0, 0,   1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);
    vt[11] = mk(0, 1, SW,   0, 0, 0,   0, 32'h4, 1, SW, 32'h0, 3'd1, 0);
    vt[12] = mk(0, 1, BAD,  0, 0, 1,   0, 32'h4, 1, SW, 32'h0, 3'd1, 0);
    vt[13] = mk(0, 1, BAD,  0, 0, 1,   0, 32'h4, 1, SW, 32'h0, 3'd1, 0);
    vt[14] = mk(0, 1, BAD,  0, 0, 1,   0, 32'h4, 1, SW, 32'h0, 3'd1, 0);
    vt[15] = mk(0, 1, BAD,  0, 0, 1,   0, 32'h4, 1, SW, 32'h0, 3'd1, 0);
    vt[16] = mk(0, 0, BAD,  0, 0, 0,   1, 32'h4, 0, SW, 32'h0, 3'd1, 0);
    vt[17] = mk(0, 1, ADDI, 1, 32'h103, 0, 1, 32'h100, 0, SW, 32'h0, 3'd1, 0);
    vt[18] = mk(0, 1, BEQ,  0, 0, 0,   0, 32'h104, 1, BEQ, 32'h100, 3'd2, 0);
    vt[19] = mk(0, 0, BEQ,  1, 32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 0, BEQ, 32'h100, 3'd2, 0);
    vt[20] = mk(0, 1, JAL,  0, 0, 0,   0, 32'h0, 1, JAL, 32'hFFFFFFFC, 3'd3, 0);
    vt[21] = mk(0, 0, JAL,  0, 0, 0,   1, 32'h0, 0, JAL, 32'hFFFFFFFC, 3'd3, 0);
    vt[22] = mk(0, 1, LUI,  0, 0, 0,   0, 32'h4, 1, LUI, 32'h0, 3'd4, 0);
    vt[23] = mk(0, 0, LUI,  0, 0, 0,   1, 32'h4, 0, LUI, 32'h0, 3'd4, 0);
    vt[24] = mk(0, 1, BAD,  0, 0, 0,   0, 32'h8, 1, BAD, 32'h4, 3'd0, 1);
    vt[25] = mk(1, 1, ADDI, 1, 32'h200, 1, 1, 32'h0, 0, 32'h0, 32'h0, 3'd0, 0);

    for (int i = 0; i < 26; i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].rdata, vt[i].redir, vt[i].tgt, vt[i].stl);
      chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vt[i].e_req});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d valid", i), {31'b0, instruction_valid}, {31'b0, vt[i].e_vld});
      chk($sformatf("v%0d full_instruction", i), full_instruction, vt[i].e_fi);
      chk($sformatf("v%0d instruction_pc", i), instruction_pc, vt[i].e_ipc);
      chk($sformatf("v%0d immediate_source", i), {29'b0, immediate_source}, {29'b0, vt[i].e_imm});
      chk($sformatf("v%0d illegal_opcode", i), {31'b0, illegal_opcode}, {31'b0, vt[i].e_ill});
    end

    // Redirect to a misaligned target while memory is not ready: address stays word aligned.
    step(0, 0, 0, 1, 32'h00000307, 0);
    chk("misaligned redirect addr", mem_addr, 32'h00000304);
    chk("misaligned redirect req", {31'b0, mem_req}, 32'd1);

    // Memory becomes ready two cycles later; valid must appear within a bounded wait.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wait addr stable", mem_addr, 32'h00000304);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000000F;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk);
      #1;
      if (instruction_valid) got = 1'b1;
    end
    total++;
    if (got) passed++;
    else $display("FAIL wait valid: got timeout expected valid within 8 cycles");
    chk("fence ipc", instruction_pc, 32'h00000304);
    chk("fence legal", {31'b0, illegal_opcode}, 32'd0);
    chk("fence next addr", mem_addr, 32'h00000308);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
